// File: rtl/microcontroller_pkg.sv
// microcontroller_pkg: opcodes, field widths and sequencer states shared by the microcontroller blocks
package microcontroller_pkg;
  localparam int OP_W = 4;
  localparam int P1_W = 6;
  localparam int P2_W = 6;
  localparam int INSTR_W = OP_W + P1_W + P2_W;
  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_LOAD = 4'h8;
  localparam logic [OP_W-1:0] OP_STORE = 4'h9;
  localparam logic [OP_W-1:0] OP_JMP = 4'hE;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, ISSUE_ALU, WAIT_ALU, ISSUE_MEM, WAIT_MEM, HALTED, ERROR
  } seq_state_t;
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return !op[OP_W-1] && op != OP_NOP;
  endfunction
  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return op == OP_LOAD || op == OP_STORE;
  endfunction
endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog: counts waiting cycles and flags the cycle whose count reaches TIMEOUT-1
module seq_watchdog #(
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT) + 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  logic [W-1:0] cnt;
  // cleared on issue, advances on every waiting cycle without done
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
  assign expired = en && (cnt + W'(1) == LAST);
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/issue FSM dispatching instructions to the ALU and load/store controllers
module instr_sequencer
  import microcontroller_pkg::*;
#(
  parameter int TIMEOUT = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [INSTR_W-1:0] instr,
  output logic               ir_load,
  output logic [OP_W-1:0]    opcode,
  output logic [P1_W-1:0]    param1,
  output logic [P2_W-1:0]    param2,
  output logic               alu_activate,
  input  logic               alu_done,
  output logic               mem_activate,
  input  logic               mem_done,
  output logic               pc_inc,
  output logic               pc_load,
  output logic               busy,
  output logic               halted,
  output logic               err
);
  seq_state_t state_q, state_d;
  logic wd_clear, wd_en, wd_expired;
  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk),
    .rst(rst),
    .clear(wd_clear),
    .en(wd_en),
    .expired(wd_expired)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // instruction register, captured while in FETCH
  always_ff @(posedge clk or posedge rst)
    if (rst) {opcode, param1, param2} <= '0;
    else if (state_q == FETCH) {opcode, param1, param2} <= instr;
  // next-state decode; a done arriving on the timeout cycle still completes the instruction
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = run ? FETCH : IDLE;
      FETCH:     state_d = DECODE;
      DECODE:    state_d = opcode == OP_NOP ? IDLE :
                           is_alu_op(opcode) ? ISSUE_ALU :
                           is_mem_op(opcode) ? ISSUE_MEM :
                           opcode == OP_JMP ? IDLE :
                           opcode == OP_HALT ? HALTED : ERROR;
      ISSUE_ALU: state_d = WAIT_ALU;
      WAIT_ALU:  state_d = alu_done ? IDLE : wd_expired ? ERROR : WAIT_ALU;
      ISSUE_MEM: state_d = WAIT_MEM;
      WAIT_MEM:  state_d = mem_done ? IDLE : wd_expired ? ERROR : WAIT_MEM;
      HALTED:    state_d = HALTED;
      ERROR:     state_d = ERROR;
      default:   state_d = ERROR;
    endcase
  end
  assign wd_clear = state_q == ISSUE_ALU || state_q == ISSUE_MEM;
  assign wd_en = (state_q == WAIT_ALU && !alu_done) || (state_q == WAIT_MEM && !mem_done);
  assign ir_load = state_q == FETCH;
  assign alu_activate = state_q == ISSUE_ALU;
  assign mem_activate = state_q == ISSUE_MEM;
  assign pc_inc = state_q == DECODE && opcode == OP_NOP;
  assign pc_load = state_q == DECODE && opcode == OP_JMP;
  assign halted = state_q == HALTED;
  assign err = state_q == ERROR;
  assign busy = !(state_q == IDLE || halted || err);
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed scenarios with a pulse scoreboard for instr_sequencer
module tb_instr_sequencer;
  logic clk = 0, rst = 1, run = 0, alu_done = 0, mem_done = 0;
  logic [15:0] instr = '0;
  logic ir_load, alu_activate, mem_activate, pc_inc, pc_load, busy, halted, err;
  logic [3:0] opcode;
  logic [5:0] param1, param2;
  int cyc = 0, base = 0, checks = 0, passes = 0, fails = 0;
  typedef struct {logic [4:0] p; int c;} ev_t;
  ev_t exp_q[$];
  ev_t e;
  logic [4:0] pv;
  localparam logic [4:0] P_IR = 5'b10000, P_ALU = 5'b01000, P_MEM = 5'b00100, P_INC = 5'b00010, P_LD = 5'b00001;

  instr_sequencer #(.TIMEOUT(32)) dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .ir_load(ir_load),
    .opcode(opcode), .param1(param1), .param2(param2),
    .alu_activate(alu_activate), .alu_done(alu_done),
    .mem_activate(mem_activate), .mem_done(mem_done),
    .pc_inc(pc_inc), .pc_load(pc_load), .busy(busy), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic ev(input logic [4:0] p, input int c);
    exp_q.push_back('{p: p, c: c});
  endtask

  task automatic start();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    base = cyc;
  endtask

  task automatic at(input int n);
    while (cyc - base < n) @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_pulses"}, {ir_load, alu_activate, mem_activate, pc_inc, pc_load}, 0);
    chk({tag, "_flags"}, {busy, halted, err}, 0);
    chk({tag, "_ir"}, {opcode, param1, param2}, 0);
  endtask

  always @(negedge clk) begin
    pv = {ir_load, alu_activate, mem_activate, pc_inc, pc_load};
    if (!rst && pv != 0) begin
      if (exp_q.size() == 0) chk("unexpected_pulse", {27'd0, pv}, 0);
      else begin
        e = exp_q.pop_front();
        chk("pulse_kind", {27'd0, pv}, {27'd0, e.p});
        chk("pulse_cycle", cyc - base, e.c);
      end
    end
  end

  initial begin
    #1 chk_quiet("reset");
    instr = 16'h1042; run = 1;
    ev(P_IR, 1); ev(P_ALU, 3);
    start();
    at(2); chk("alu_fields", {opcode, param1, param2}, {4'h1, 6'd1, 6'd2}); chk("alu_busy_dec", busy, 1);
    at(5); mem_done = 1;
    at(8); mem_done = 0;
    at(12); chk("alu_wait_busy", busy, 1); alu_done = 1; run = 0;
    at(13); alu_done = 0; chk("alu_idle", {busy, halted, err}, 0);
    at(17); chk("alu_q_empty", exp_q.size(), 0);

    instr = 16'hE015; run = 1;
    ev(P_IR, 1); ev(P_LD, 2);
    start();
    at(2); chk("jmp_param2", param2, 6'h15); run = 0;
    at(6); chk("jmp_idle", busy, 0); chk("jmp_q_empty", exp_q.size(), 0);

    instr = 16'h8000; run = 1;
    ev(P_IR, 1); ev(P_MEM, 3);
    start();
    at(34); chk("wd_pre_err", {busy, err}, 2'b10);
    at(35); chk("wd_err", {busy, err}, 2'b01);
    at(45); chk("wd_err_sticky", err, 1); chk("wd_q_empty", exp_q.size(), 0);

    instr = 16'h9000; run = 1;
    ev(P_IR, 1); ev(P_MEM, 3);
    start();
    at(34); mem_done = 1; run = 0;
    at(35); mem_done = 0; chk("done_wins", {busy, err}, 0);
    at(38); chk("done_wins_q", exp_q.size(), 0);

    instr = 16'hF000; run = 1;
    ev(P_IR, 1);
    start();
    at(3); chk("halt_flags", {busy, halted, err}, 3'b010);
    at(10); chk("halt_sticky", halted, 1); chk("halt_q_empty", exp_q.size(), 0);
    #2 rst = 1; run = 0;
    #1 chk_quiet("halt_rst");

    instr = 16'h1042; run = 1;
    ev(P_IR, 1); ev(P_ALU, 3);
    start();
    at(6); chk("wait_busy", busy, 1);
    #2 rst = 1; run = 0;
    #1 chk_quiet("async_rst");
    @(negedge clk); @(negedge clk);
    alu_done = 1; rst = 0; base = cyc;
    at(3); alu_done = 0; chk("spurious_done", {busy, halted, err}, 0);
    at(6); chk("rst_q_empty", exp_q.size(), 0);

    instr = 16'hA000; run = 1;
    ev(P_IR, 1);
    start();
    at(3); chk("illegal_err", {busy, err}, 2'b01);
    at(6); chk("illegal_q", exp_q.size(), 0);

    instr = 16'h0000; run = 1;
    ev(P_IR, 1); ev(P_INC, 2); ev(P_IR, 4); ev(P_INC, 5);
    start();
    at(4); run = 0;
    at(9); chk("nop_idle", busy, 0); chk("nop_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
